// File: rtl/display_timing_gen.sv
// ---------------------------------------------------------------------------
// display_timing_gen
//
// Parametrised raster timing generator. It produces the beam position,
// data enable, hsync/vsync with a configurable asserted level per axis,
// line/frame start strobes and a frame counter. Every output is a register
// loaded from the *next* beam position, so de/hsync/vsync always describe
// the (sx,sy) shown in the same cycle. A pixel enable lets a fast clock
// drive a slower pixel rate.
//
// Ports:
//   pix_clk      in   clock
//   rst_pix      in   synchronous active-high reset (overrides en)
//   en           in   pixel enable; the beam advances only when en=1
//   sx, sy       out  beam position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//   de           out  beam is inside the active area
//   hsync/vsync  out  sync pulses at H_POL / V_POL level while asserted
//   line_start   out  one-clock strobe when sx has just become 0
//   frame_start  out  one-clock strobe when (sx,sy) has just become (0,0)
//   frame_cnt    out  index of the current frame (wraps mod 2^FRAMEW)
// ---------------------------------------------------------------------------
module display_timing_gen #(
  parameter int   CORDW    = 10,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0,
  parameter int   FRAMEW   = 16
) (
  input  logic              pix_clk,
  input  logic              rst_pix,
  input  logic              en,
  output logic [CORDW-1:0]  sx,
  output logic [CORDW-1:0]  sy,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              line_start,
  output logic              frame_start,
  output logic [FRAMEW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sync windows are kept as inclusive bounds so a zero back porch cannot
  // push the end value past the coordinate range.
  localparam logic [CORDW-1:0] H_LAST     = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST     = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT      = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT      = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_FIRST   = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_LAST    = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CORDW-1:0] VS_FIRST   = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_LAST    = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);

  if (H_TOTAL > (2 ** CORDW) || V_TOTAL > (2 ** CORDW)) begin : g_cordw_too_small
    $error("display_timing_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_timing
    $error("display_timing_gen: active and sync widths must be at least 1");
  end

  logic [CORDW-1:0]  r_sx, r_sy;
  logic              r_de, r_hsync, r_vsync, r_line_start, r_frame_start;
  logic [FRAMEW-1:0] r_frame_cnt;

  logic [CORDW-1:0]  w_sx_nxt, w_sy_nxt;
  logic              w_de_nxt, w_hsync_nxt, w_vsync_nxt;
  logic              w_line_start_nxt, w_frame_start_nxt;

  // Next beam position and everything derived from it. Registering these
  // (rather than decoding the current position) is what gives zero skew
  // between the coordinates and de/hsync/vsync.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned -- that is what keeps latches from being inferred.
    w_sx_nxt = r_sx + CORDW'(1);
    w_sy_nxt = r_sy;
    if (r_sx == H_LAST) begin
      w_sx_nxt = '0;
      w_sy_nxt = (r_sy == V_LAST) ? '0 : r_sy + CORDW'(1);
    end

    w_de_nxt    = (w_sx_nxt < H_ACT) && (w_sy_nxt < V_ACT);
    w_hsync_nxt = (w_sx_nxt >= HS_FIRST && w_sx_nxt <= HS_LAST) ? H_POL : ~H_POL;
    w_vsync_nxt = (w_sy_nxt >= VS_FIRST && w_sy_nxt <= VS_LAST) ? V_POL : ~V_POL;

    w_line_start_nxt  = (w_sx_nxt == '0);
    w_frame_start_nxt = w_line_start_nxt && (w_sy_nxt == '0);
  end

  always_ff @(posedge pix_clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_pix) begin
      // Park the beam on the last pixel of the frame so the first enabled
      // edge wraps to (0,0) and raises both strobes with frame_cnt -> 0.
      r_sx          <= H_LAST;
      r_sy          <= V_LAST;
      r_de          <= 1'b0;
      r_hsync       <= ~H_POL;
      r_vsync       <= ~V_POL;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '1;
    end else if (en) begin
      r_sx          <= w_sx_nxt;
      r_sy          <= w_sy_nxt;
      r_de          <= w_de_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_line_start  <= w_line_start_nxt;
      r_frame_start <= w_frame_start_nxt;
      if (w_frame_start_nxt) begin
        r_frame_cnt <= r_frame_cnt + FRAMEW'(1);
      end
    end else begin
      // Strobes stay one clock wide even when en is held low afterwards.
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign sx          = r_sx;
  assign sy          = r_sy;
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;

endmodule

// File: doc/display_timing_gen.md
Name: display_timing_gen

Overview:
Parametrised raster timing generator: the successor to the fixed 640x480 display signal block. It produces beam coordinates, data enable, hsync/vsync with per-axis configurable polarity, line/frame start strobes and a frame counter, all registered. A pixel-enable input lets one fast clock drive slower pixel rates. It sits between the pixel clock domain and the drawing/pong logic and the video output pins.

Parameters:
CORDW, 10, width of sx/sy; must hold max(H_TOTAL,V_TOTAL)-1 (elaboration-time assertion)
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active-low, 1 = active-high)
V_POL, 0, vsync asserted level
FRAMEW, 16, frame counter width

Ports:
pix_clk  input  1  clock
rst_pix  input  1  synchronous active-high reset
en  input  1  pixel enable; counters advance only on edges where en=1
sx  output  CORDW  horizontal position, 0..H_TOTAL-1
sy  output  CORDW  vertical position, 0..V_TOTAL-1
de  output  1  high while (sx,sy) is in the active area
hsync  output  1  horizontal sync at H_POL level while asserted
vsync  output  1  vertical sync at V_POL level while asserted
line_start  output  1  one-clock strobe when sx becomes 0
frame_start  output  1  one-clock strobe when (sx,sy) becomes (0,0)
frame_cnt  output  FRAMEW  index of the current frame

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Per-line order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical order is the same.
- Counter: on an en=1 edge, sx<=sx+1. If sx==H_TOTAL-1, then sx<=0 and sy<=sy+1, with sy wrapping from V_TOTAL-1 to 0. sx never reaches H_TOTAL and sy never reaches V_TOTAL.
- en=0 edge: sx, sy, de, hsync, vsync and frame_cnt hold their values. line_start and frame_start are 0 on the following cycle.
- All outputs are registered; there is no combinational path from any input to any output.
  - de, hsync and vsync are computed from the next-position values.
  - They therefore always describe the (sx,sy) presented in the same cycle, with zero skew.
- de = (sx<H_ACTIVE) && (sy<V_ACTIVE).
- hsync = H_POL when sx is in the sync window, else ~H_POL. vsync is the same using sy and V_POL; vsync changes together with sx becoming 0.
- line_start = 1 in the cycle after an en=1 edge that loaded sx=0. frame_start additionally requires sy=0.
- frame_cnt increments (mod 2^FRAMEW) on the same edge that raises frame_start.
- Reset values (rst_pix=1 on an edge, which overrides en):
  - sx=H_TOTAL-1, sy=V_TOTAL-1, de=0
  - hsync=~H_POL, vsync=~V_POL
  - line_start=0, frame_start=0, frame_cnt=all-ones
  - The first en=1 edge after reset therefore yields sx=0, sy=0, de=1, line_start=1, frame_start=1, frame_cnt=0.
- Reset mid-line or mid-frame: reset takes effect on that edge and all outputs take their reset values; no partial frame is flagged.
- Latency: one enabled edge from counter update to all outputs; the strobes are one clock wide regardless of the en duty cycle.

Test Plan:
- Defaults, en=1, run 2 frames: sx period 800 and sy period 525. de high exactly 640 clocks per line on lines 0-479 (307200 per frame). hsync low for sx in 656..751, vsync low for sy in 490..491. frame_cnt goes 0, then 1.
- Reset release: first en edge gives (0,0), de=1, line_start=frame_start=1, frame_cnt=0. Assert rst_pix at (sx=300,sy=200): the next cycle shows sx=799, sy=524, de=0, hsync=vsync=1.
- en toggling 1,0 (half rate), defaults: one line spans 1600 clocks. line_start is high for 1 clock per line, and outputs hold through en=0 cycles.
- H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, CORDW=4, H_POL=V_POL=1:
  - sx sequence 0..7 with de high for sx 0..3 when sy<3.
  - hsync high for sx 5,6; vsync high only on line 4.
  - A frame is 48 clocks.
- FRAMEW=2, small config, run 5 frames: frame_cnt sequence 0,1,2,3,0 with one frame_start per wrap.
- Wrap corner: at (H_TOTAL-1,V_TOTAL-1) with en=1, the next cycle gives sx=0, sy=0, and line_start, frame_start and de are all high in the same cycle.
